heap_op_arbiter: RTL and testbench

HEAP_OP_ARBITER -- requirements
Module: heap_op_arbiter

---
 rtl/heap_op_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_heap_op_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/heap_op_arbiter.sv
// heap_op_arbiter: round-robin front end that serialises push/pop requests
// from NREQ requesters onto a single heap engine, tracks occupancy, screens
// out requests that cannot succeed, and aborts engine operations that hang.
module heap_op_arbiter #(
  parameter int NREQ  = 4,
  parameter int DW    = 32,
  parameter int DEPTH = 256,
  parameter int TMO   = 1024,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_v,
  input  logic [2*NREQ-1:0]    req_op,
  input  logic [DW*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      resp_v,
  output logic                 resp_ok,
  output logic [DW-1:0]        resp_data,
  output logic                 eng_v,
  output logic [1:0]           eng_op,
  output logic [DW-1:0]        eng_data,
  input  logic                 eng_ready,
  input  logic                 eng_done,
  input  logic [DW-1:0]        eng_rdata,
  output logic [CW-1:0]        count,
  output logic                 err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [1:0] OP_PUSH = 2'd1;
  localparam logic [1:0] OP_POP  = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   rr_q, rr_d;
  logic [PW-1:0]   idx_q, idx_d;
  logic [1:0]      op_q, op_d;
  logic [DW-1:0]   data_q, data_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            ok_q, ok_d;
  logic [DW-1:0]   rdata_q, rdata_d;

  logic            gnt_found;
  logic [PW-1:0]   gnt_idx;
  logic [1:0]      sel_op;
  logic [DW-1:0]   sel_data;
  logic            reject;

  // Round-robin search for the first valid requester starting at rr_q.
  always_comb begin
    int cand;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int i = 0; i < NREQ; i++) begin
      cand = (int'(rr_q) + i) % NREQ;
      if (!gnt_found && req_v[cand[PW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[PW-1:0];
      end
    end
  end

  // Pick the winner's opcode and operand, and decide whether it can succeed.
  always_comb begin
    sel_op   = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == PW'(i)) begin
        sel_op   = req_op[2*i +: 2];
        sel_data = req_data[DW*i +: DW];
      end
    end
    reject = ((sel_op != OP_PUSH) && (sel_op != OP_POP)) ||
             ((sel_op == OP_PUSH) && (cnt_q == CW'(DEPTH))) ||
             ((sel_op == OP_POP)  && (cnt_q == '0));
  end

  // Next-state logic: one operation in flight, timeout shared by ISSUE and WAIT.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    idx_d   = idx_q;
    op_d    = op_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    ok_d    = ok_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          idx_d  = gnt_idx;
          op_d   = sel_op;
          data_d = sel_data;
          rr_d   = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
          if (reject) begin
            state_d = S_RESP;
            ok_d    = 1'b0;
            rdata_d = '0;
          end else begin
            state_d = S_ISSUE;
            tmo_d   = '0;
          end
        end
      end
      S_ISSUE: begin
        tmo_d = tmo_q + 1'b1;
        if (eng_ready) begin
          state_d = S_WAIT;
        end else if (tmo_q == TW'(TMO-1)) begin
          state_d = S_RESP;
          ok_d    = 1'b0;
          rdata_d = '0;
          err_d   = 1'b1;
        end
      end
      S_WAIT: begin
        tmo_d = tmo_q + 1'b1;
        if (eng_done) begin
          state_d = S_RESP;
          ok_d    = 1'b1;
          if (op_q == OP_POP) begin
            rdata_d = eng_rdata;
            cnt_d   = cnt_q - 1'b1;
          end else begin
            rdata_d = '0;
            cnt_d   = cnt_q + 1'b1;
          end
        end else if (tmo_q == TW'(TMO-1)) begin
          state_d = S_RESP;
          ok_d    = 1'b0;
          rdata_d = '0;
          err_d   = 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      idx_q   <= '0;
      op_q    <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
      ok_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      ok_q    <= ok_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs are decoded from state so they are zero outside their own state.
  always_comb begin
    req_ready = '0;
    resp_v    = '0;
    if (state_q == S_IDLE && gnt_found && !reset) req_ready[gnt_idx] = 1'b1;
    if (state_q == S_RESP) resp_v[idx_q] = 1'b1;
    resp_ok   = (state_q == S_RESP) && ok_q;
    resp_data = (state_q == S_RESP) ? rdata_q : '0;
    eng_v     = (state_q == S_ISSUE);
    eng_op    = (state_q == S_ISSUE) ? op_q : 2'd0;
    eng_data  = (state_q == S_ISSUE) ? data_q : '0;
    count     = cnt_q;
    err       = err_q;
  end

endmodule

// File: tb/tb_heap_op_arbiter.sv
// Bench for heap_op_arbiter: directed scenarios feed a scoreboard queue, a
// negedge monitor checks each response, and a behavioural max-heap engine
// answers the engine port.
module tb_heap_op_arbiter;
  localparam int NREQ  = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_v;
  logic [2*NREQ-1:0]    req_op;
  logic [DW*NREQ-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      resp_v;
  logic                 resp_ok;
  logic [DW-1:0]        resp_data;
  logic                 eng_v;
  logic [1:0]           eng_op;
  logic [DW-1:0]        eng_data;
  logic                 eng_ready;
  logic                 eng_done;
  logic [DW-1:0]        eng_rdata;
  logic [CW-1:0]        count;
  logic                 err;

  heap_op_arbiter #(.NREQ(NREQ), .DW(DW), .DEPTH(DEPTH), .TMO(TMO)) dut (
    .clk(clk), .reset(reset),
    .req_v(req_v), .req_op(req_op), .req_data(req_data), .req_ready(req_ready),
    .resp_v(resp_v), .resp_ok(resp_ok), .resp_data(resp_data),
    .eng_v(eng_v), .eng_op(eng_op), .eng_data(eng_data),
    .eng_ready(eng_ready), .eng_done(eng_done), .eng_rdata(eng_rdata),
    .count(count), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NREQ-1:0] v;
    logic            ok;
    logic [DW-1:0]   d;
    logic [CW-1:0]   cnt;
    logic            e;
    int              lat;
  } exp_t;

  exp_t  exp_q[$];
  int    acc_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    acc_cnt = 0;
  bit    eng_seen = 1'b0;
  bit    eng_never = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic expect_resp(input int r, input logic ok, input logic [DW-1:0] d,
                             input int cnt, input logic e, input int lat);
    exp_t x;
    x.v   = '0;
    x.v[r] = 1'b1;
    x.ok  = ok;
    x.d   = d;
    x.cnt = CW'(cnt);
    x.e   = e;
    x.lat = lat;
    exp_q.push_back(x);
  endtask

  // Called at posedge+#1; holds the request until granted, then drops it.
  task automatic issue(input int idx, input logic [1:0] op, input logic [DW-1:0] d);
    bit got;
    got = 1'b0;
    req_op[2*idx +: 2]    = op;
    req_data[DW*idx +: DW] = d;
    req_v[idx]            = 1'b1;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (req_ready[idx]) got = 1'b1;
      @(posedge clk); #1;
    end
    req_v[idx] = 1'b0;
    chk("grant_seen", 64'(got), 64'd1);
  endtask

  task automatic drain(input int bound);
    for (int k = 0; k < bound && exp_q.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    chk("drain_remaining", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_resp_v"},    64'(resp_v),    64'd0);
    chk({tag, "_resp_ok"},   64'(resp_ok),   64'd0);
    chk({tag, "_resp_data"}, 64'(resp_data), 64'd0);
    chk({tag, "_eng_v"},     64'(eng_v),     64'd0);
    chk({tag, "_eng_op"},    64'(eng_op),    64'd0);
    chk({tag, "_eng_data"},  64'(eng_data),  64'd0);
    chk({tag, "_count"},     64'(count),     64'd0);
    chk({tag, "_err"},       64'(err),       64'd0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural max-heap engine: done in the first WAIT cycle unless told to hang.
  initial begin
    logic [DW-1:0] heap[$];
    bit            hs;
    bit            rst;
    logic [1:0]    o;
    logic [DW-1:0] d;
    logic [DW-1:0] r;
    int            mi;
    eng_done  = 1'b0;
    eng_rdata = '0;
    forever begin
      @(negedge clk);
      hs  = eng_v && eng_ready;
      o   = eng_op;
      d   = eng_data;
      rst = reset;
      @(posedge clk); #1;
      eng_done  = 1'b0;
      eng_rdata = '0;
      if (rst) heap.delete();
      else if (hs && !eng_never) begin
        r = '0;
        if (o == 2'd1) heap.push_back(d);
        else if (heap.size() != 0) begin
          mi = 0;
          for (int i = 1; i < heap.size(); i++) if (heap[i] > heap[mi]) mi = i;
          r = heap[mi];
          heap.delete(mi);
        end
        eng_done  = 1'b1;
        eng_rdata = r;
      end
    end
  end

  // Monitor: logs acceptances and scores each response pulse.
  initial begin
    exp_t x;
    int   a;
    forever begin
      @(negedge clk);
      if (reset) acc_q.delete();
      else begin
        if (|(req_v & req_ready)) begin
          acc_q.push_back(cyc);
          acc_cnt++;
        end
        if (eng_v) eng_seen = 1'b1;
        if (|resp_v) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: resp_v=%b with no response expected", resp_v);
          end else begin
            x = exp_q.pop_front();
            a = (acc_q.size() != 0) ? acc_q.pop_front() : -1000;
            chk("resp_v",    64'(resp_v),    64'(x.v));
            chk("resp_ok",   64'(resp_ok),   64'(x.ok));
            chk("resp_data", 64'(resp_data), 64'(x.d));
            chk("count",     64'(count),     64'(x.cnt));
            chk("err",       64'(err),       64'(x.e));
            chk("latency",   64'(cyc - a),   64'(x.lat));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  // Directed stimulus.
  initial begin
    reset = 1'b1; req_v = '0; req_op = '0; req_data = '0; eng_ready = 1'b1;
    // Requests during reset must not be granted.
    req_v = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("reset");
    @(posedge clk); #1;
    req_v = '0;

    // Pop on empty, issued in the first cycle after release: rejected, 1-cycle latency.
    reset = 1'b0;
    eng_seen = 1'b0;
    expect_resp(1, 1'b0, '0, 0, 1'b0, 1);
    req_op[3:2] = 2'd2;
    req_v[1] = 1'b1;
    @(negedge clk);
    chk("first_grant", 64'(req_ready), 64'b0010);
    @(posedge clk); #1;
    req_v[1] = 1'b0;
    drain(20);
    chk("pop_empty_no_eng_v", 64'(eng_seen), 64'd0);

    // Illegal opcode: rejected without touching the engine.
    eng_seen = 1'b0;
    expect_resp(0, 1'b0, '0, 0, 1'b0, 1);
    issue(0, 2'd3, 32'h1234);
    drain(20);
    chk("illegal_no_eng_v", 64'(eng_seen), 64'd0);

    // Requester 2 pushes 0x55; requester 1 pulses req_v while busy and is ignored.
    expect_resp(2, 1'b1, '0, 1, 1'b0, 3);
    issue(2, 2'd1, 32'h55);
    req_op[3:2] = 2'd1;
    req_v[1] = 1'b1;
    @(posedge clk); #1;
    req_v[1] = 1'b0;
    drain(20);

    // Max-heap ordering: push 7, 3, 9 then pop three times.
    do_reset();
    expect_resp(0, 1'b1, '0, 1, 1'b0, 3); issue(0, 2'd1, 32'd7); drain(20);
    expect_resp(1, 1'b1, '0, 2, 1'b0, 3); issue(1, 2'd1, 32'd3); drain(20);
    expect_resp(3, 1'b1, '0, 3, 1'b0, 3); issue(3, 2'd1, 32'd9); drain(20);
    expect_resp(0, 1'b1, 32'd9, 2, 1'b0, 3); issue(0, 2'd2, '0); drain(20);
    expect_resp(1, 1'b1, 32'd7, 1, 1'b0, 3); issue(1, 2'd2, '0); drain(20);
    expect_resp(2, 1'b1, 32'd3, 0, 1'b0, 3); issue(2, 2'd2, '0); drain(20);

    // Engine stalls 3 cycles in ISSUE: command must stay stable.
    eng_ready = 1'b0;
    expect_resp(3, 1'b1, '0, 1, 1'b0, 6);
    issue(3, 2'd1, 32'hAB);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_eng_v",    64'(eng_v),    64'd1);
      chk("stall_eng_op",   64'(eng_op),   64'd1);
      chk("stall_eng_data", 64'(eng_data), 64'hAB);
      @(posedge clk); #1;
    end
    eng_ready = 1'b1;
    drain(20);

    // All four push continuously: order 0,1,2,3, then 0 again rejected on full.
    do_reset();
    for (int i = 0; i < NREQ; i++) expect_resp(i, 1'b1, '0, i + 1, 1'b0, 3);
    expect_resp(0, 1'b0, '0, DEPTH, 1'b0, 1);
    req_op   = 8'b01_01_01_01;
    req_data = {32'h13, 32'h12, 32'h11, 32'h10};
    acc_cnt  = 0;
    req_v    = 4'hF;
    for (int k = 0; k < 200 && acc_cnt < 5; k++) begin
      @(posedge clk); #1;
    end
    req_v = '0;
    chk("five_grants", 64'(acc_cnt), 64'd5);
    drain(20);

    // Engine hangs: abort after TMO cycles in ISSUE/WAIT, err sticks.
    do_reset();
    eng_never = 1'b1;
    expect_resp(0, 1'b0, '0, 0, 1'b1, TMO + 1);
    issue(0, 2'd1, 32'h11);
    drain(200);
    eng_never = 1'b0;
    expect_resp(1, 1'b1, '0, 1, 1'b1, 3);
    issue(1, 2'd1, 32'h22);
    drain(20);

    // Reset asserted in WAIT: operation dropped silently, everything cleared.
    eng_never = 1'b1;
    issue(2, 2'd1, 32'h33);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("wait_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    eng_never = 1'b0;
    repeat (TMO + 5) @(posedge clk);
    #1;

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
